// File: rtl/share_split.sv
// Boolean masking encoder: splits one unmasked word into NUM_SHARES shares
// using NUM_SHARES-1 fresh random words, so that the XOR of all shares equals the input.
module share_split #(
    parameter int NUM_SHARES    = 2,
    parameter int ELEMENT_WIDTH = 8
) (
    input  logic                                     in_clock,
    input  logic                                     in_reset_n,
    input  logic [ELEMENT_WIDTH-1:0]                 in_value,
    input  logic                                     in_valid,
    output logic                                     out_ready,
    input  logic [ELEMENT_WIDTH-1:0]                 in_random,
    input  logic                                     in_random_valid,
    output logic                                     out_random_ready,
    output logic [NUM_SHARES-1:0][ELEMENT_WIDTH-1:0] out_shares,
    output logic                                     out_valid,
    input  logic                                     in_ready
);
    localparam int CW = $clog2(NUM_SHARES);
    localparam logic [CW-1:0] LAST = CW'(NUM_SHARES - 2);

    generate
        if (NUM_SHARES < 2) begin : g_bad_num_shares
            $error("share_split: NUM_SHARES must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} state_t;

    state_t                                  state, state_nxt;
    logic [ELEMENT_WIDTH-1:0]                acc;
    logic [CW-1:0]                           cnt;
    logic [NUM_SHARES-1:0][ELEMENT_WIDTH-1:0] shares;
    logic                                    in_fire, rnd_fire;

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        out_ready        = 1'b0;
        out_random_ready = 1'b0;
        out_valid        = 1'b0;
        case (state)
            IDLE: begin
                out_ready = 1'b1;
                if (in_valid) state_nxt = COLLECT;
            end
            COLLECT: begin
                out_random_ready = 1'b1;
                if (in_random_valid && cnt == LAST) state_nxt = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (in_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_fire  = in_valid & out_ready;
    assign rnd_fire = in_random_valid & out_random_ready;

    // acc carries the unmasked value and is only ever folded into the last share,
    // never exposed on its own.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            acc    <= '0;
            cnt    <= '0;
            shares <= '0;
        end else begin
            if (in_fire) begin
                acc <= in_value;
                cnt <= '0;
            end
            if (rnd_fire) begin
                shares[cnt] <= in_random;
                if (cnt == LAST) begin
                    shares[NUM_SHARES-1] <= acc ^ in_random;
                end else begin
                    acc <= acc ^ in_random;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign out_shares = shares;

endmodule
